// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue controller with a 4-entry, 4-bit register file.
// It feeds an external ALU. Optional macro ALU_ZERO_FLAG_EN adds zero_flag.
module alu_issue_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [8:0] instr,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_sel,
    input  logic [3:0] alu_result,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic [1:0] res_rd
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic       zero_flag
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0] rf [4];
    logic [1:0] rd_q;

    logic [2:0] opc;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [3:0] imm;
    logic       take;
    logic       is_alu;
    logic       is_ld;
    logic       res_we;
    logic [3:0] res_nxt;
    logic [1:0] res_rd_nxt;

    assign opc = instr[8:6];
    assign rd  = instr[5:4];
    assign rs1 = instr[3:2];
    assign rs2 = instr[1:0];
    assign imm = instr[3:0];

    assign instr_ready = (state == IDLE) && !rst;
    assign res_valid   = (state == RESP);

    // Decode the offered instruction and select the value to write back
    always_comb begin
        take       = instr_valid && instr_ready;
        is_alu     = !opc[2];
        is_ld      = (opc == 3'b100);
        res_we     = 1'b0;
        res_nxt    = imm;
        res_rd_nxt = rd;
        if (state == EXEC) begin
            res_we     = 1'b1;
            res_nxt    = alu_result;
            res_rd_nxt = rd_q;
        end else if (take && is_ld) begin
            res_we = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (take && is_alu) begin
                    state_nxt = EXEC;
                end else if (take && is_ld) begin
                    state_nxt = RESP;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture; operands are read before any write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a   <= 4'd0;
            alu_b   <= 4'd0;
            alu_sel <= 2'd0;
            rd_q    <= 2'd0;
        end else if (take && is_alu) begin
            alu_a   <= rf[rs1];
            alu_b   <= rf[rs2];
            alu_sel <= opc[1:0];
            rd_q    <= rd;
        end
    end

    // Register file and result write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rf[i] <= 4'd0;
            end
            res_data <= 4'd0;
            res_rd   <= 2'd0;
        end else if (res_we) begin
            rf[res_rd_nxt] <= res_nxt;
            res_data       <= res_nxt;
            res_rd         <= res_rd_nxt;
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    // Zero flag follows every result write
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_flag <= 1'b0;
        end else if (res_we) begin
            zero_flag <= (res_nxt == 4'd0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed plus random instructions for alu_issue_ctrl,
// checked against an architectural register-file model.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [8:0] instr;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_sel;
    logic [3:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [1:0] res_rd;
`ifdef ALU_ZERO_FLAG_EN
    logic       zero_flag;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int m_rf [4];

    always #5 clk = ~clk;

    // Downstream ALU: shifts act on operand a
    always_comb begin
        unique case (alu_sel)
            2'd0: alu_result = alu_a + alu_b;
            2'd1: alu_result = alu_a - alu_b;
            2'd2: alu_result = {alu_a[2:0], 1'b0};
            default: alu_result = {1'b0, alu_a[3:1]};
        endcase
    end

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_rd     (res_rd)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .zero_flag  (zero_flag)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        instr_valid = 1'b0;
        res_ready   = 1'b0;
        instr       = '0;
        tick();
        tick();
        foreach (m_rf[i]) m_rf[i] = 0;
        check("rst_rdy", instr_ready, 0);
        check("rst_vld", res_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_sel", alu_sel, 0);
        check("rst_data", res_data, 0);
        check("rst_rd", res_rd, 0);
`ifdef ALU_ZERO_FLAG_EN
        check("rst_zf", zero_flag, 0);
`endif
        rst = 1'b0;
        #1;
        check("post_rst_rdy", instr_ready, 1);
    endtask

    // Issue one instruction and retire it after 'stall' back-pressure cycles
    task automatic do_op(input logic [8:0] ins, input int stall);
        int  opc;
        int  rd;
        int  a;
        int  b;
        int  r;
        bit  is_alu;
        bit  is_ld;
        opc    = int'(ins[8:6]);
        rd     = int'(ins[5:4]);
        a      = m_rf[ins[3:2]];
        b      = m_rf[ins[1:0]];
        is_alu = (opc < 4);
        is_ld  = (opc == 4);
        case (opc % 4)
            0: r = (a + b) % 16;
            1: r = (a - b + 16) % 16;
            2: r = (a * 2) % 16;
            default: r = a / 2;
        endcase
        if (is_ld) r = int'(ins[3:0]);

        check("issue_rdy", instr_ready, 1);
        instr_valid = 1'b1;
        instr       = ins;
        res_ready   = 1'b0;
        tick();
        // keep offering junk; it must be ignored outside IDLE
        instr = 9'($urandom);
        if (!is_alu && !is_ld) begin
            instr_valid = 1'b0;
            check("bad_vld", res_valid, 0);
            check("bad_rdy", instr_ready, 1);
            return;
        end
        if (is_alu) begin
            check("exec_vld", res_valid, 0);
            check("exec_rdy", instr_ready, 0);
            check("exec_a", alu_a, a);
            check("exec_b", alu_b, b);
            tick();
        end
        m_rf[rd] = r;
        check("vld", res_valid, 1);
        check("data", res_data, r);
        check("rd", res_rd, rd);
`ifdef ALU_ZERO_FLAG_EN
        check("zf", zero_flag, (r == 0) ? 1 : 0);
`endif
        for (int k = 0; k < stall; k++) begin
            tick();
            check("hold_vld", res_valid, 1);
            check("hold_data", res_data, r);
            check("hold_rd", res_rd, rd);
            check("hold_rdy", instr_ready, 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready   = 1'b0;
        instr_valid = 1'b0;
        check("done_vld", res_valid, 0);
        check("done_rdy", instr_ready, 1);
    endtask

    function automatic logic [8:0] ld(input int rd, input int v);
        return {3'b100, 2'(rd), 4'(v)};
    endfunction

    function automatic logic [8:0] op(input int o, input int rd, input int s1, input int s2);
        return {3'(o), 2'(rd), 2'(s1), 2'(s2)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] ri;
        do_reset();

        do_op(ld(0, 5), 0);
        do_op(ld(1, 3), 0);
        do_op(op(0, 2, 0, 1), 0);
        do_op(op(1, 2, 1, 0), 0);
        do_op(ld(3, 9), 0);
        do_op(op(2, 1, 3, 0), 0);
        do_op(op(3, 0, 3, 0), 5);
        do_op(op(6, 2, 1, 1), 0);
        do_op(op(0, 3, 2, 2), 0);
        do_op(ld(0, 7), 0);
        do_op(op(0, 0, 0, 0), 0);
        do_op(op(0, 1, 0, 0), 0);
        do_op(ld(0, 4), 0);
        do_op(op(1, 0, 0, 0), 0);
        do_op(ld(1, 1), 2);

        // reset while an ADD into r2 is executing
        do_op(ld(0, 5), 0);
        do_op(ld(1, 3), 0);
        instr_valid = 1'b1;
        instr       = op(0, 2, 0, 1);
        tick();
        instr_valid = 1'b0;
        check("abort_exec_vld", res_valid, 0);
        rst = 1'b1;
        #1;
        check("abort_rst_rdy", instr_ready, 0);
        tick();
        foreach (m_rf[i]) m_rf[i] = 0;
        rst = 1'b0;
        #1;
        check("abort_rdy", instr_ready, 1);
        check("abort_vld", res_valid, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_idle_vld", res_valid, 0);
        end
        do_op(ld(0, 5), 0);
        do_op(op(0, 3, 2, 0), 0);

        for (int n = 0; n < 300; n++) begin
            ri = 9'($urandom);
            if ($urandom_range(0, 2) == 0) ri[8:6] = 3'b100;
            do_op(ri, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
